// File: rtl/vmm_serializer_nch_pkg.sv
// vmm_ser_pkg: shared definitions for the multi-channel bit-serial operand
// feeder (vmm_serializer_nch).
//   - ser_state_e : frame FSM states
//   - clog2()     : ceiling log2 helper for counter sizing
//   - frame_len() : bits per frame (DATA_W, or DATA_W + EXT_BITS when
//                   SERIAL_SIGN_EXT_EN is defined)
// Build option: SERIAL_SIGN_EXT_EN (adds EXT_BITS sign-extension cycles).
package vmm_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } ser_state_e;

`ifdef SERIAL_SIGN_EXT_EN
  localparam bit SIGN_EXT_EN = 1'b1;
`else
  localparam bit SIGN_EXT_EN = 1'b0;
`endif

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned ext_bits);
    return data_w + (SIGN_EXT_EN ? ext_bits : 0);
  endfunction

endpackage

// File: rtl/vmm_serializer_nch_ser_lane.sv
// ser_lane: one channel of the bit-serial feeder. Holds the captured word,
// shifts it out LSB-first and produces the two's-complement negation of the
// same stream on the fly (pass bits through up to and including the first 1,
// invert everything after it).
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   load, word    capture a new word
//   shift_en      emit sreg[0] and shift right
//   seen_clr      clear the "a 1 has been emitted" flag at frame start
//   out_clr       zero the serial outputs at the end of a frame
//   ser_bit       registered current bit of the word
//   ser_neg       registered current bit of the negated word
// Build option: SERIAL_SIGN_EXT_EN (arithmetic shift so the MSB repeats).
module ser_lane
  import vmm_ser_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              shift_en,
  input  logic              seen_clr,
  input  logic              out_clr,
  output logic              ser_bit,
  output logic              ser_neg
);

  logic [DATA_W-1:0] sreg;
  logic              seen_one;
  logic              fill;

  // Refilling with the MSB makes every extension cycle re-emit bit DATA_W-1.
  assign fill = SIGN_EXT_EN ? sreg[DATA_W-1] : 1'b0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sreg     <= '0;
      seen_one <= 1'b0;
      ser_bit  <= 1'b0;
      ser_neg  <= 1'b0;
    end else begin
      if (load) begin
        sreg <= word;
      end else if (shift_en) begin
        sreg <= {fill, sreg[DATA_W-1:1]};
      end

      if (seen_clr) begin
        seen_one <= 1'b0;
      end else if (shift_en) begin
        seen_one <= seen_one | sreg[0];
      end

      if (shift_en) begin
        ser_bit <= sreg[0];
        ser_neg <= sreg[0] ^ seen_one;
      end else if (out_clr) begin
        ser_bit <= 1'b0;
        ser_neg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vmm_serializer_nch.sv
// vmm_serializer_nch: captures NUM_CH parallel words and streams each one
// LSB-first together with its two's-complement negation, feeding the
// bit-serial inputs of the reservoir VMM MAC array.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   Parallel_In     channel c at [c*DATA_W +: DATA_W]
//   load_valid      word set offered; accepted when load_ready
//   load_ready      IDLE or LOADED (decoded from state)
//   start           stream the loaded set (LOADED only, load has priority)
//   Serial_Out      current bit of each word
//   Serial_Out_neg  current bit of each negated word
//   bit_valid       Serial_Out* carry bit bit_idx
//   bit_idx         index of current bit
//   last_bit        final bit of the frame
//   busy            SHIFT or DONE (decoded from state)
//   done            one-cycle pulse after the frame
// Build option: SERIAL_SIGN_EXT_EN (frame grows to DATA_W + EXT_BITS).
module vmm_serializer_nch
  import vmm_ser_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned EXT_BITS = 4,
  localparam int unsigned FRAME_L  = frame_len(DATA_W, EXT_BITS),
  localparam int unsigned CNT_W    = clog2(FRAME_L + 1)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_CH*DATA_W-1:0] Parallel_In,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     start,
  output logic [NUM_CH-1:0]        Serial_Out,
  output logic [NUM_CH-1:0]        Serial_Out_neg,
  output logic                     bit_valid,
  output logic [CNT_W-1:0]         bit_idx,
  output logic                     last_bit,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_L - 1);

  ser_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load_cap;
  logic             start_go;
  logic             shift_en;
  logic             out_clr;

  assign load_ready = (state == S_IDLE) || (state == S_LOADED);
  assign busy       = (state == S_SHIFT) || (state == S_DONE);

  always_comb begin
    state_nxt = state;
    load_cap  = 1'b0;
    start_go  = 1'b0;
    shift_en  = 1'b0;
    out_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_valid) begin
          load_cap  = 1'b1;
          state_nxt = S_LOADED;
        end
      end
      S_LOADED: begin
        if (load_valid) begin
          load_cap = 1'b1;
        end else if (start) begin
          start_go  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_valid <= 1'b0;
      bit_idx   <= '0;
      last_bit  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= out_clr;
      if (start_go) cnt <= '0;
      if (shift_en) begin
        bit_valid <= 1'b1;
        bit_idx   <= cnt;
        last_bit  <= (cnt == LAST_IDX);
        cnt       <= cnt + CNT_W'(1);
      end else if (out_clr) begin
        bit_valid <= 1'b0;
        bit_idx   <= '0;
        last_bit  <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    ser_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .Clk      (Clk),
      .Rst      (Rst),
      .load     (load_cap),
      .word     (Parallel_In[g*DATA_W +: DATA_W]),
      .shift_en (shift_en),
      .seen_clr (start_go),
      .out_clr  (out_clr),
      .ser_bit  (Serial_Out[g]),
      .ser_neg  (Serial_Out_neg[g])
    );
  end

endmodule

// File: doc/vmm_serializer_nch.md
Name: vmm_serializer_nch

Overview:
- Parametrised multi-channel, bit-serial operand feeder for the reservoir-computing vector-matrix multiplier.
- Captures NUM_CH parallel words and streams each one LSB-first.
- Alongside each stream it emits the two's-complement negation of the same word, also LSB-first; the negation is computed bit-serially, so no W-bit adder is needed.
- Replaces per-word single-channel shifters; drives the MAC array's bit-serial inputs and signals frame boundaries.

Parameters:
- DATA_W, 32, bits per word per channel.
- NUM_CH, 4, number of parallel channels.
- EXT_BITS, 4, extra sign-extension cycles; used only with SERIAL_SIGN_EXT_EN.

Ports:
- Clk  in  1  system clock, rising edge only.
- Rst  in  1  synchronous, active-high reset.
- Parallel_In  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- load_valid  in  1  parallel word set offered.
- load_ready  out  1  block can accept a load (IDLE or LOADED).
- start  in  1  begin streaming the loaded set.
- Serial_Out  out  NUM_CH  current bit of each word.
- Serial_Out_neg  out  NUM_CH  current bit of the negated word.
- bit_valid  out  1  Serial_Out / Serial_Out_neg carry bit bit_idx.
- bit_idx  out  CNT_W  index of the current bit; CNT_W = clog2(frame length + 1).
- last_bit  out  1  final bit of the frame.
- busy  out  1  state is SHIFT or DONE.
- done  out  1  one-cycle pulse after the frame ends.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes happen on the rising edge of Clk. All outputs are registered except load_ready and busy, which are decoded from state.
- Reset values: state IDLE; shift registers and negation flags 0; Serial_Out, Serial_Out_neg, bit_valid, bit_idx, last_bit, done all 0; load_ready 1; busy 0.
- States are IDLE, LOADED, SHIFT, DONE.
- IDLE:
  - load_valid → capture all channels, go to LOADED.
  - start is ignored.
- LOADED:
  - load_valid → recapture, stay in LOADED.
  - load_valid and start in the same cycle → the load wins and start is ignored.
  - start alone → go to SHIFT; clear the per-channel seen_one flags and the counter.
- SHIFT timing, with start sampled at edge E0:
  - Edge E(i+1), for i = 0..L-1, registers bit i; L = DATA_W, or DATA_W + EXT_BITS with the macro.
  - At edge E(i+1): Serial_Out[c] = b = sreg[c][0]; Serial_Out_neg[c] = seen_one[c] ? ~b : b; then seen_one[c] |= b; sreg shifts right.
  - bit_valid = 1, bit_idx = i, and last_bit = 1 when i = L-1.
  - After the edge that emits i = L-1, go to DONE.
- DONE:
  - Entry edge clears Serial_Out, Serial_Out_neg, bit_valid and bit_idx, and sets done = 1 for exactly one cycle.
  - Next edge returns to IDLE.
- Arithmetic: Serial_Out_neg yields (2^DATA_W − x) mod 2^DATA_W.
  - x = 0 gives 0.
  - x = 0x8000_0000 gives 0x8000_0000 (wrap; no flag).
- Data is consumed by a frame. start in IDLE after DONE is ignored until a new load.
- start held high during SHIFT or DONE has no effect. load_valid during SHIFT or DONE is not accepted (load_ready = 0).
- Rst at any point, including mid-SHIFT: next edge gives reset values and IDLE; no done pulse.

Optional Feature:
- SERIAL_SIGN_EXT_EN defined:
  - Frame length is DATA_W + EXT_BITS.
  - In the extension cycles, Serial_Out repeats input bit DATA_W-1.
  - Serial_Out_neg continues the seen_one rule on that repeated bit, giving the correctly sign-extended negation.
  - bit_idx counts up to DATA_W + EXT_BITS − 1.
- Not defined: frame is exactly DATA_W bits and EXT_BITS is unused.

Decomposition:
- Package vmm_ser_pkg holds:
  - the state enum (IDLE, LOADED, SHIFT, DONE);
  - the clog2 helper;
  - the frame-length and CNT_W constants.
- One sub-module, ser_lane: a single channel's shift register, seen_one flop and negation XOR. It is instantiated NUM_CH times.
- The FSM, counter and handshake logic stay in the top level.

Test Plan:
- Rst high for 2 cycles → all outputs 0, load_ready 1, busy 0; start alone afterwards → no bit_valid.
- NUM_CH=2; ch0=0x0000_0005, ch1=0xFFFF_FFFF; load then start →
  - ch0 Serial_Out 1,0,1,0,… and Serial_Out_neg gives 0xFFFF_FFFB;
  - ch1 Serial_Out_neg gives 0x0000_0001;
  - last_bit at bit_idx 31; done pulses once on the following edge.
- ch0=0x0000_0000, ch1=0x8000_0000 → negated streams are 0x0000_0000 and 0x8000_0000.
- load_valid and start together → state stays LOADED, no stream. Reload 0x1234_5678 and then start → the second value is streamed.
- Rst asserted while bit_idx = 10 → next cycle IDLE, all outputs 0, no done; a later start without load is ignored.
- SERIAL_SIGN_EXT_EN, EXT_BITS=4, ch0=0xFFFF_FFFE → 36 bits:
  - Serial_Out extension bits are 1,1,1,1;
  - Serial_Out_neg gives 0x0_0000_0002 with extension bits 0;
  - last_bit at bit_idx 35.
